// File: rtl/pe_pkg.sv
// Shared definitions for the streaming convolution PE (pe_stream_mac).
// Contents:
//   - Default parameter constants.
//   - FSM state enum.
//   - Signed saturation helper.
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned KDEPTH_DEF = 16;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned OUT_W_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OUT
  } pe_state_e;

  // Clamp a signed value into the signed range of a w-bit result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pe_stream_mac_if.sv
// Sample-in / result-out stream bundle for pe_stream_mac.
// Signals:
//   - x_valid, x_ready, x_data : input sample handshake.
//   - y_valid, y_ready, y_data, y_ovf : result handshake.
// Modports:
//   - slave  : the PE side.
//   - master : the neighbouring datapath side (window buffer / collector).
interface pe_stream_mac_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 12
) ();
  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;
  logic              y_valid;
  logic              y_ready;
  logic [OUT_W-1:0]  y_data;
  logic              y_ovf;

  modport slave  (input  x_valid, x_data, y_ready,
                  output x_ready, y_valid, y_data, y_ovf);
  modport master (output x_valid, x_data, y_ready,
                  input  x_ready, y_valid, y_data, y_ovf);
endinterface

// File: rtl/pe_kernel_buf.sv
// Kernel tap register file for pe_stream_mac.
// Ports:
//   - clk, rst_n : clock and asynchronous active-low reset (clears all taps).
//   - wr_en      : write one lane group (already gated by the PE FSM).
//   - wr_addr    : lane-group index; lane i lands in tap wr_addr*LANES+i.
//   - wr_data    : packed taps, lane 0 in the LSBs.
//   - rd_addr    : tap index.
//   - rd_data    : combinational read of the addressed tap.
module pe_kernel_buf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned KDEPTH = KDEPTH_DEF,
  parameter int unsigned LANES  = LANES_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [$clog2(KDEPTH/LANES)-1:0]  wr_addr,
  input  logic [LANES*DATA_W-1:0]          wr_data,
  input  logic [$clog2(KDEPTH)-1:0]        rd_addr,
  output logic signed [DATA_W-1:0]         rd_data
);
  localparam int unsigned KIDX_W = $clog2(KDEPTH);

  logic signed [DATA_W-1:0] taps [KDEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '{default: '0};
    end else if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        taps[KIDX_W'(wr_addr * LANES + i)] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = taps[rd_addr];

endmodule

// File: rtl/pe_stream_mac.sv
// Streaming convolution PE: multiplies each accepted input sample by the
// current kernel tap, accumulates over k_len taps and presents one result.
// Ports:
//   - clk, rst_n  : clock and asynchronous active-low reset.
//   - k_wr_en, k_wr_addr, k_wr_data : lane-group kernel load (IDLE only).
//   - k_len       : taps per result, sampled on start (0 or >KDEPTH => KDEPTH).
//   - start       : begin one accumulation (IDLE only).
//   - busy        : high in RUN and OUT.
//   - strm        : sample/result stream bundle (slave side).
// Build option: PE_SAT_EN defined clamps the result to the signed OUT_W range
// and flags y_ovf; otherwise the result is truncated and y_ovf stays 0.
module pe_stream_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned KDEPTH = KDEPTH_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             k_wr_en,
  input  logic [$clog2(KDEPTH/LANES)-1:0]  k_wr_addr,
  input  logic [LANES*DATA_W-1:0]          k_wr_data,
  input  logic [$clog2(KDEPTH):0]          k_len,
  input  logic                             start,
  output logic                             busy,
  pe_stream_mac_if.slave                   strm
);
  localparam int unsigned KIDX_W = $clog2(KDEPTH);
  localparam int unsigned KLEN_W = KIDX_W + 1;

  pe_state_e                 state;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic [KLEN_W-1:0]         idx;
  logic [KLEN_W-1:0]         len;
  logic [KLEN_W-1:0]         len_eff;
  logic signed [DATA_W-1:0]  tap;
  logic signed [2*DATA_W-1:0] prod;
  logic                      x_hs;
  logic [OUT_W-1:0]          y_next;
  logic                      ovf_next;

  pe_kernel_buf #(
    .DATA_W (DATA_W),
    .KDEPTH (KDEPTH),
    .LANES  (LANES)
  ) u_kbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (k_wr_en && (state == ST_IDLE)),
    .wr_addr (k_wr_addr),
    .wr_data (k_wr_data),
    .rd_addr (idx[KIDX_W-1:0]),
    .rd_data (tap)
  );

  always_comb begin
    len_eff = k_len;
    if (k_len == '0 || k_len > KLEN_W'(KDEPTH)) len_eff = KLEN_W'(KDEPTH);
  end

  assign x_hs     = strm.x_valid & strm.x_ready;
  assign prod     = $signed(strm.x_data) * tap;
  assign acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // The result register is loaded from acc_next on the final handshake so
  // that y_valid rises the cycle after the last sample, not one later.
`ifdef PE_SAT_EN
  logic signed [63:0] sat;
  always_comb begin
    sat      = sat_clamp(64'(acc_next), OUT_W);
    y_next   = sat[OUT_W-1:0];
    ovf_next = (sat != 64'(acc_next));
  end
`else
  always_comb begin
    y_next   = acc_next[OUT_W-1:0];
    ovf_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      idx          <= '0;
      len          <= '0;
      busy         <= 1'b0;
      strm.x_ready <= 1'b0;
      strm.y_valid <= 1'b0;
      strm.y_data  <= '0;
      strm.y_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len          <= len_eff;
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b1;
            strm.x_ready <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (x_hs) begin
            acc <= acc_next;
            idx <= idx + KLEN_W'(1);
            if (idx == len - KLEN_W'(1)) begin
              strm.x_ready <= 1'b0;
              strm.y_valid <= 1'b1;
              strm.y_data  <= y_next;
              strm.y_ovf   <= ovf_next;
              state        <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (strm.y_ready) begin
            strm.y_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_mac.sv
// Self-checking bench for pe_stream_mac: expected results are computed from a
// tap/sample model and queued at start; a monitor pops and compares them on
// every result handshake.
module tb_pe_stream_mac;
  import pe_pkg::*;

  localparam int KD = 16;
  localparam int LN = 4;
  localparam int OW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        k_wr_en = 1'b0;
  logic [1:0]  k_wr_addr = '0;
  logic [31:0] k_wr_data = '0;
  logic [4:0]  k_len = '0;
  logic        start = 1'b0;
  logic        busy;

  pe_stream_mac_if #(.DATA_W(8), .OUT_W(OW)) ifc ();

  pe_stream_mac #(
    .DATA_W (8),
    .KDEPTH (KD),
    .LANES  (LN),
    .ACC_W  (20),
    .OUT_W  (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .k_wr_en   (k_wr_en),
    .k_wr_addr (k_wr_addr),
    .k_wr_data (k_wr_data),
    .k_len     (k_len),
    .start     (start),
    .busy      (busy),
    .strm      (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          o;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   mtaps [KD];
  int   xs [32];
  exp_t sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc.y_valid && ifc.y_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("y_data", 64'(ifc.y_data), 64'(e.d));
        check("y_ovf", 64'(ifc.y_ovf), 64'(e.o));
      end
    end
  end

  function automatic exp_t predict(input int n);
    exp_t        e;
    int          acc;
    logic [31:0] a;
    acc = 0;
    for (int i = 0; i < n; i++) acc += mtaps[i] * xs[i];
    a = acc;
`ifdef PE_SAT_EN
    if (acc > 2047) begin
      e.d = 12'h7ff; e.o = 1'b1;
    end else if (acc < -2048) begin
      e.d = 12'h800; e.o = 1'b1;
    end else begin
      e.d = a[OW-1:0]; e.o = 1'b0;
    end
`else
    e.d = a[OW-1:0];
    e.o = 1'b0;
`endif
    return e;
  endfunction

  task automatic wr_group(input int a, input int v0, input int v1, input int v2, input int v3);
    k_wr_en   = 1'b1;
    k_wr_addr = 2'(a);
    k_wr_data = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    cyc();
    k_wr_en   = 1'b0;
    mtaps[a*LN+0] = v0;
    mtaps[a*LN+1] = v1;
    mtaps[a*LN+2] = v2;
    mtaps[a*LN+3] = v3;
  endtask

  task automatic run_mac(input string tag, input int len_in, input bit gaps,
                         input int hold, input bit poke);
    int            eff;
    int            to;
    bit            hs;
    logic [OW-1:0] saved;
    eff = (len_in == 0 || len_in > KD) ? KD : len_in;
    sb.push_back(predict(eff));
    k_len = 5'(len_in);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    check({tag, "_xready_start"}, 64'(ifc.x_ready), 64'd1);
    for (int i = 0; i < eff; i++) begin
      if (gaps && i > 0) begin
        ifc.x_valid = 1'b0;
        cyc();
      end
      ifc.x_valid = 1'b1;
      ifc.x_data  = 8'(xs[i]);
      if (poke && i == 1) begin
        start = 1'b1; k_wr_en = 1'b1; k_wr_addr = '0; k_wr_data = '1;
      end
      if (i == eff - 1) check({tag, "_yvalid_early"}, 64'(ifc.y_valid), 64'd0);
      to = 0;
      do begin
        hs = ifc.x_ready;
        cyc();
        start = 1'b0; k_wr_en = 1'b0;
        to++;
      end while (!hs && to < 50);
      if (!hs) begin
        check({tag, "_x_hs_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    ifc.x_valid = 1'b0;
    check({tag, "_yvalid_after"}, 64'(ifc.y_valid), 64'd1);
    check({tag, "_xready_out"}, 64'(ifc.x_ready), 64'd0);
    saved = ifc.y_data;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        start = 1'b1; k_wr_en = 1'b1; k_wr_addr = 2'd1; k_wr_data = '1;
      end
      cyc();
      start = 1'b0; k_wr_en = 1'b0;
      check({tag, "_hold_valid"}, 64'(ifc.y_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(ifc.y_data), 64'(saved));
    end
    ifc.y_ready = 1'b1;
    cyc();
    ifc.y_ready = 1'b0;
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_yvalid_done"}, 64'(ifc.y_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int to;
    bit hs;
    ifc.x_valid = 1'b0;
    ifc.x_data  = '0;
    ifc.y_ready = 1'b0;
    for (int i = 0; i < KD; i++) mtaps[i] = 0;
    repeat (2) cyc();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_xready", 64'(ifc.x_ready), 64'd0);
    check("rst_yvalid", 64'(ifc.y_valid), 64'd0);
    check("rst_ydata", 64'(ifc.y_data), 64'd0);
    check("rst_yovf", 64'(ifc.y_ovf), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Ramp kernel, unit samples: 1+2+...+16 = 136
    wr_group(0, 1, 2, 3, 4);
    wr_group(1, 5, 6, 7, 8);
    wr_group(2, 9, 10, 11, 12);
    wr_group(3, 13, 14, 15, 16);
    for (int i = 0; i < 32; i++) xs[i] = 1;
    run_mac("ramp", 16, 1'b0, 0, 1'b0);

    // Extreme negatives: 16 * 16384 = 262144
    for (int g = 0; g < 4; g++) wr_group(g, -128, -128, -128, -128);
    for (int i = 0; i < 32; i++) xs[i] = -128;
    run_mac("extreme", 16, 1'b0, 0, 1'b0);

    // Short kernel with stalls: 2*5 - 3*5 + 4*5 = 15
    wr_group(0, 2, -3, 4, 0);
    for (int i = 0; i < 32; i++) xs[i] = 5;
    run_mac("short_gaps", 3, 1'b1, 0, 1'b0);

    // k_len 0 and k_len beyond depth both use all 16 taps
    for (int i = 0; i < 32; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
    run_mac("len0", 0, 1'b0, 2, 1'b0);
    run_mac("len20", 20, 1'b1, 0, 1'b0);

    // Output held, start/kernel writes poked during RUN and OUT are ignored
    wr_group(0, 3, -7, 11, -1);
    wr_group(1, 25, -40, 6, 9);
    for (int i = 0; i < 32; i++) xs[i] = int'($urandom_range(0, 60)) - 30;
    run_mac("hold_poke", 8, 1'b0, 5, 1'b1);
    run_mac("after_poke", 8, 1'b0, 0, 1'b0);

    // Reset in the middle of a run after 7 taps
    k_len = 5'd16;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ifc.x_valid = 1'b1;
      ifc.x_data  = 8'(i + 1);
      to = 0;
      do begin
        hs = ifc.x_ready;
        cyc();
        to++;
      end while (!hs && to < 50);
      if (!hs) check("midrst_x_hs_timeout", 64'd0, 64'd1);
    end
    ifc.x_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_xready", 64'(ifc.x_ready), 64'd0);
    check("midrst_yvalid", 64'(ifc.y_valid), 64'd0);
    check("midrst_ydata", 64'(ifc.y_data), 64'd0);
    check("midrst_yovf", 64'(ifc.y_ovf), 64'd0);
    for (int i = 0; i < KD; i++) mtaps[i] = 0;
    #2;
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 32; i++) xs[i] = 17 + i;
    run_mac("post_rst", 4, 1'b0, 0, 1'b0);

    cyc();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_stream_mac.md
# pe_stream_mac

Parametrised streaming processing element: the next generation of our convolution PE. It holds a kernel of up to `KDEPTH` signed taps, loaded `LANES` words per write. It sequences the tap index internally, so no external select is needed. It accepts one input sample per valid/ready handshake, multiplies by the current tap and accumulates, then presents one result on a valid/ready output. It sits between the input-window buffer and the output/partial-sum collector of the CNN datapath.

## Interface
Parameters:
- `DATA_W`, 8, width of kernel taps and input samples (signed two's complement)
- `KDEPTH`, 16, kernel buffer depth; must be a multiple of `LANES`
- `LANES`, 4, kernel words written per load cycle
- `ACC_W`, 20, accumulator width; must be ≥ 2·`DATA_W` + clog2(`KDEPTH`)
- `OUT_W`, 12, result width; must be ≤ `ACC_W`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `k_wr_en`  in  1  write one lane group into the kernel buffer
- `k_wr_addr`  in  clog2(`KDEPTH`/`LANES`)  lane-group index; lane i goes to tap `k_wr_addr`·`LANES`+i
- `k_wr_data`  in  `LANES`·`DATA_W`  packed taps, lane 0 in the LSBs
- `k_len`  in  clog2(`KDEPTH`)+1  number of taps used per result, sampled on start
- `start`  in  1  begin one accumulation
- `busy`  out  1  high in RUN and OUT
- `x_valid`  in  1  input sample valid
- `x_ready`  out  1  PE accepts a sample
- `x_data`  in  `DATA_W`  input sample
- `y_valid`  out  1  result valid
- `y_ready`  in  1  downstream accepts the result
- `y_data`  out  `OUT_W`  signed result
- `y_ovf`  out  1  result was clamped; valid with `y_valid`

## Operation
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - `start`=1 latches `k_len`; 0 or any value > `KDEPTH` is treated as `KDEPTH`.
  - Clears the accumulator, sets tap index to 0, moves to RUN.
- RUN:
  - `x_ready`=1.
  - Each `x_valid`&`x_ready` cycle adds sext(`x_data`)·sext(tap[index]) to the accumulator and increments the index.
  - The handshake on index `k_len`−1 moves to OUT.
- OUT:
  - `y_valid`=1. `y_data` and `y_ovf` are registered and held stable until `y_ready`=1.
  - The `y_ready`=1 cycle returns to IDLE.
- Accumulator arithmetic is signed, `ACC_W` bits, and wraps; the parameter constraints guarantee wrap cannot occur.
- `start` outside IDLE is ignored.
- Kernel writes are honoured only in IDLE; in RUN and OUT they are ignored, so taps are stable for the whole accumulation.
- Reset (any time, including mid-RUN or mid-OUT):
  - State returns to IDLE; accumulator and all kernel taps are cleared to 0.
  - `busy`, `x_ready`, `y_valid`, `y_ovf` reset to 0; `y_data` resets to 0.

## Timing
- Kernel write: the tap is visible from the cycle after `k_wr_en`.
- `start` at cycle t → `busy`=1 and `x_ready`=1 at t+1.
- Throughput: one tap per cycle while `x_valid` stays high; `x_valid` gaps stall the PE with no state loss.
- Final input handshake at cycle t → `y_valid`=1 at t+1. `x_ready`=0 from t+1 until the next RUN.
- `y_ready` may be high before `y_valid`. Result handshake at cycle t → IDLE at t+1, so the next `start` is accepted at t+1 at the earliest.
- Minimum result period: `k_len`+2 cycles.
- Output registers only; there is no combinational path from `x_*` or `y_ready` to outputs.

## Configuration
- `PE_SAT_EN` defined:
  - `y_data` is the accumulator clamped to the signed `OUT_W` range [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
  - `y_ovf`=1 when clamping occurred.
- `PE_SAT_EN` undefined:
  - `y_data` = accumulator[`OUT_W`−1:0] (truncation).
  - `y_ovf` is tied 0.
- The port list is identical in both builds.

## Structure
- Shared package `pe_pkg`:
  - FSM state enum typedef (IDLE/RUN/OUT).
  - Default parameter constants.
  - Helper function for the saturation clamp.
- Sub-module `pe_kernel_buf`:
  - Kernel register file with lane-group write port, write enable gated by the FSM, async-reset clear, and indexed combinational read.
- FSM, tap counter, MAC and output register live in the top module.

## Test plan
- Load taps 1..16 in 4 writes; `k_len`=16; stream x=1 with no gaps → `y_data`=136, `y_ovf`=0, `y_valid` exactly 1 cycle after the 16th handshake.
- Taps all −128, x all −128, `k_len`=16 → acc 262144. With `PE_SAT_EN`: `y_data`=2047, `y_ovf`=1. Without it: `y_data`=0, `y_ovf`=0.
- `k_len`=3, taps 2,−3,4, x=5,5,5 with `x_valid` toggling every other cycle → `y_data`=15; stalls add no error; `k_len`=0 run uses all 16 taps.
- Hold `y_ready`=0 for 5 cycles in OUT → `y_data`/`y_valid` stable. `start` and `k_wr_en` pulsed during RUN/OUT → ignored; next result uses the old taps.
- Assert `rst_n`=0 mid-RUN after 7 taps → all outputs 0 immediately; after release a fresh `k_len`=4 run gives the correct sum over zeroed taps (0).
